apb_slave_mem: RTL and testbench

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_mem_array.sv | 26 ++
 rtl/apb_slave_mem.sv | 124 ++++++++++++
 tb/tb_apb_slave_mem.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB slave memory.
// The FSM state enum and the default sizing live here.
package apb_pkg;

   localparam int APB_DW    = 32;
   localparam int APB_AW    = 32;
   localparam int DEF_DEPTH = 256;
   localparam int DEF_WAIT  = 1;

   typedef enum logic {
      IDLE,
      ACCESS
   } apb_state_e;

endpackage

// File: rtl/apb_mem_array.sv
// Single-port word storage for the APB slave.
// Writes are synchronous; reads are combinational.
module apb_mem_array
   import apb_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [APB_DW-1:0] wdata,
   output logic [APB_DW-1:0] rdata
);

   logic [APB_DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave with a word-addressed memory and a fixed
// number of wait states per transfer.
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int          DEPTH       = DEF_DEPTH,
   parameter int          WAIT_STATES = DEF_WAIT,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              psel,
   input  logic              penable,
   input  logic [APB_AW-1:0] paddr,
   input  logic              pwrite,
   input  logic [APB_DW-1:0] pwdata,
   output logic [APB_DW-1:0] prdata,
   output logic              pready,
   output logic              pslverr
);

   localparam int AW = $clog2(DEPTH);

   apb_state_e        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic              write_q, write_d;
   logic [APB_DW-1:0] wdata_q, wdata_d;
   logic [APB_DW-1:0] prdata_q, prdata_d;

   logic [AW-1:0]     idx_in;
   logic              in_range;
   logic              setup_err;
   logic              setup;
   logic              ready;
   logic              done;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [APB_DW-1:0] mem_rdata;

   // BASE_ADDR is aligned to the array size, so the upper bits decide range
   assign idx_in    = paddr[AW+1:2];
   assign in_range  = paddr[APB_AW-1:AW+2] == BASE_ADDR[APB_AW-1:AW+2];
   assign setup_err = (paddr[1:0] != 2'b00) || !in_range;

   assign setup    = (state_q == IDLE) && psel && !penable;
   assign ready    = (state_q == ACCESS) && (cnt_q == 4'd0);
   assign done     = ready && psel && penable;
   assign mem_we   = done && write_q && !err_q && rst_n;
   assign mem_addr = (state_q == IDLE) ? idx_in : addr_q;

   apb_mem_array #(
      .DEPTH(DEPTH)
   ) u_mem (
      .clk  (pclk),
      .we   (mem_we),
      .addr (mem_addr),
      .wdata(wdata_q),
      .rdata(mem_rdata)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      addr_d   = addr_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      prdata_d = prdata_q;
      unique case (state_q)
         IDLE: begin
            if (setup) begin
               state_d = ACCESS;
               cnt_d   = 4'(WAIT_STATES);
               err_d   = setup_err;
               addr_d  = idx_in;
               write_d = pwrite;
               wdata_d = pwdata;
               if (!pwrite) begin
                  prdata_d = setup_err ? '0 : mem_rdata;
               end
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (penable) begin
               if (cnt_q != 4'd0) begin
                  cnt_d = cnt_q - 4'd1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         prdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         prdata_q <= prdata_d;
      end
   end

   always_ff @(posedge pclk) begin
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
   end

   assign prdata  = prdata_q;
   assign pready  = ready;
   assign pslverr = ready && err_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem with three wait-state
// configurations: 1 (dut0), 0 (dut1) and 3 (dut2).
module tb_apb_slave_mem;

   logic        pclk;
   logic        rst_n;
   logic        psel_a    [3];
   logic        penable_a [3];
   logic [31:0] paddr_a   [3];
   logic        pwrite_a  [3];
   logic [31:0] pwdata_a  [3];

   logic [31:0] prdata0, prdata1, prdata2;
   logic        pready0, pready1, pready2;
   logic        pslverr0, pslverr1, pslverr2;

   int checks = 0;
   int errors = 0;

   apb_slave_mem #(.DEPTH(256), .WAIT_STATES(1)) dut0 (
      .pclk(pclk), .rst_n(rst_n),
      .psel(psel_a[0]), .penable(penable_a[0]),
      .paddr(paddr_a[0]), .pwrite(pwrite_a[0]),
      .pwdata(pwdata_a[0]), .prdata(prdata0),
      .pready(pready0), .pslverr(pslverr0)
   );

   apb_slave_mem #(.DEPTH(256), .WAIT_STATES(0)) dut1 (
      .pclk(pclk), .rst_n(rst_n),
      .psel(psel_a[1]), .penable(penable_a[1]),
      .paddr(paddr_a[1]), .pwrite(pwrite_a[1]),
      .pwdata(pwdata_a[1]), .prdata(prdata1),
      .pready(pready1), .pslverr(pslverr1)
   );

   apb_slave_mem #(.DEPTH(256), .WAIT_STATES(3)) dut2 (
      .pclk(pclk), .rst_n(rst_n),
      .psel(psel_a[2]), .penable(penable_a[2]),
      .paddr(paddr_a[2]), .pwrite(pwrite_a[2]),
      .pwdata(pwdata_a[2]), .prdata(prdata2),
      .pready(pready2), .pslverr(pslverr2)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   function automatic logic [31:0] rd(input int k);
      case (k)
         0:       return prdata0;
         1:       return prdata1;
         default: return prdata2;
      endcase
   endfunction

   function automatic logic rdy(input int k);
      case (k)
         0:       return pready0;
         1:       return pready1;
         default: return pready2;
      endcase
   endfunction

   function automatic logic slverr(input int k);
      case (k)
         0:       return pslverr0;
         1:       return pslverr1;
         default: return pslverr2;
      endcase
   endfunction

   // Starts at posedge+#1; leaves psel/penable high after completion
   task automatic xfer(input int k, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit scr, output logic [31:0] rdat,
                       output logic err, output int cyc);
      bit fin;
      fin  = 0;
      cyc  = 0;
      rdat = '0;
      err  = 1'b0;
      psel_a[k]    = 1'b1;
      penable_a[k] = 1'b0;
      pwrite_a[k]  = wr;
      paddr_a[k]   = a;
      pwdata_a[k]  = d;
      @(posedge pclk); #1;
      penable_a[k] = 1'b1;
      if (scr) begin
         paddr_a[k]  = a ^ 32'h40;
         pwdata_a[k] = ~d;
         pwrite_a[k] = ~wr;
      end
      while (!fin && cyc < 32) begin
         @(negedge pclk);
         cyc++;
         if (rdy(k) === 1'b1) begin
            fin  = 1;
            rdat = rd(k);
            err  = slverr(k);
         end
         @(posedge pclk); #1;
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL timeout dut%0d addr=%h: pready never 1", k, a);
         psel_a[k]    = 1'b0;
         penable_a[k] = 1'b0;
      end
   endtask

   task automatic idle(input int k, input int n);
      psel_a[k]    = 1'b0;
      penable_a[k] = 1'b0;
      repeat (n) begin
         @(posedge pclk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge pclk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (rdy(k) !== 1'b0) begin
            errors++;
            $display("FAIL reset_pready dut%0d got=%b exp=0", k, rdy(k));
         end
         checks++;
         if (slverr(k) !== 1'b0) begin
            errors++;
            $display("FAIL reset_pslverr dut%0d got=%b exp=0", k, slverr(k));
         end
         checks++;
         if (rd(k) !== 32'h0) begin
            errors++;
            $display("FAIL reset_prdata dut%0d got=%h exp=0", k, rd(k));
         end
      end
      rst_n = 1'b1;
      @(posedge pclk); #1;
   endtask

   task automatic test_wait_one();
      logic [31:0] r;
      logic        e;
      int          c;
      xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, r, e, c);
      idle(0, 1);
      checks++;
      if (c !== 2 || e !== 1'b0) begin
         errors++;
         $display("FAIL ws1_write cycles=%0d err=%b exp 2/0", c, e);
      end
      xfer(0, 1'b0, 32'h10, 32'h0, 0, r, e, c);
      idle(0, 1);
      checks++;
      if (c !== 2 || e !== 1'b0) begin
         errors++;
         $display("FAIL ws1_read_timing cycles=%0d err=%b exp 2/0", c, e);
      end
      checks++;
      if (r !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL ws1_read_data got=%h exp=deadbeef", r);
      end
   endtask

   task automatic test_zero_wait();
      logic [31:0] r;
      logic        e;
      int          c;
      xfer(1, 1'b1, 32'h4, 32'h1234_5678, 0, r, e, c);
      idle(1, 1);
      checks++;
      if (c !== 1 || e !== 1'b0) begin
         errors++;
         $display("FAIL ws0_write cycles=%0d err=%b exp 1/0", c, e);
      end
      xfer(1, 1'b0, 32'h4, 32'h0, 0, r, e, c);
      idle(1, 1);
      checks++;
      if (c !== 1 || r !== 32'h1234_5678) begin
         errors++;
         $display("FAIL ws0_read cycles=%0d data=%h exp 1/12345678", c, r);
      end
   endtask

   task automatic test_errors();
      logic [31:0] r;
      logic        e;
      int          c;
      xfer(0, 1'b1, 32'h0, 32'hCAFE_F00D, 0, r, e, c);
      idle(0, 1);
      xfer(0, 1'b1, 32'h2, 32'h9999_9999, 0, r, e, c);
      idle(0, 1);
      checks++;
      if (e !== 1'b1) begin
         errors++;
         $display("FAIL misaligned_err got=%b exp=1", e);
      end
      xfer(0, 1'b0, 32'h0, 32'h0, 0, r, e, c);
      idle(0, 1);
      checks++;
      if (r !== 32'hCAFE_F00D || e !== 1'b0) begin
         errors++;
         $display("FAIL misaligned_nowrite data=%h err=%b exp cafef00d/0", r, e);
      end
      xfer(0, 1'b1, 32'h14, 32'h5555_5555, 0, r, e, c);
      idle(0, 1);
      checks++;
      if (rd(0) !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL prdata_hold got=%h exp=cafef00d", rd(0));
      end
      xfer(0, 1'b0, 32'h400, 32'h0, 0, r, e, c);
      idle(0, 1);
      checks++;
      if (e !== 1'b1 || r !== 32'h0) begin
         errors++;
         $display("FAIL range_read err=%b data=%h exp 1/0", e, r);
      end
   endtask

   task automatic test_latched();
      logic [31:0] r;
      logic        e;
      int          c;
      xfer(0, 1'b1, 32'h20, 32'h0BAD_CAFE, 1, r, e, c);
      idle(0, 1);
      xfer(0, 1'b0, 32'h20, 32'h0, 1, r, e, c);
      idle(0, 1);
      checks++;
      if (r !== 32'h0BAD_CAFE || e !== 1'b0) begin
         errors++;
         $display("FAIL latched_inputs data=%h err=%b exp 0badcafe/0", r, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r;
      logic        e;
      int          c;
      for (int k = 0; k < 2; k++) begin
         xfer(k, 1'b1, 32'h0, 32'hA5A5_A5A5, 0, r, e, c);
         xfer(k, 1'b0, 32'h0, 32'h0, 0, r, e, c);
         idle(k, 1);
         checks++;
         if (r !== 32'hA5A5_A5A5 || c !== 2 - k) begin
            errors++;
            $display("FAIL b2b dut%0d data=%h cycles=%0d exp a5a5a5a5/%0d",
                     k, r, c, 2 - k);
         end
      end
   endtask

   task automatic test_abort();
      logic [31:0] r;
      logic        e;
      int          c;
      xfer(2, 1'b1, 32'h8, 32'h1111_2222, 0, r, e, c);
      idle(2, 1);
      checks++;
      if (c !== 4) begin
         errors++;
         $display("FAIL ws3_write cycles=%0d exp=4", c);
      end
      psel_a[2]    = 1'b1;
      penable_a[2] = 1'b0;
      pwrite_a[2]  = 1'b1;
      paddr_a[2]   = 32'h8;
      pwdata_a[2]  = 32'hFFFF_FFFF;
      @(posedge pclk); #1;
      penable_a[2] = 1'b1;
      @(negedge pclk);
      psel_a[2]    = 1'b0;
      penable_a[2] = 1'b0;
      @(posedge pclk); #1;
      idle(2, 3);
      xfer(2, 1'b0, 32'h8, 32'h0, 0, r, e, c);
      idle(2, 1);
      checks++;
      if (r !== 32'h1111_2222 || c !== 4) begin
         errors++;
         $display("FAIL abort data=%h cycles=%0d exp 11112222/4", r, c);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      logic        e;
      int          c;
      psel_a[2]    = 1'b1;
      penable_a[2] = 1'b0;
      pwrite_a[2]  = 1'b1;
      paddr_a[2]   = 32'h8;
      pwdata_a[2]  = 32'hFFFF_FFFF;
      @(posedge pclk); #1;
      penable_a[2] = 1'b1;
      @(negedge pclk);
      rst_n = 1'b0;
      @(posedge pclk); #1;
      rst_n        = 1'b1;
      psel_a[2]    = 1'b0;
      penable_a[2] = 1'b0;
      checks++;
      if (rdy(2) !== 1'b0 || rd(2) !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset pready=%b prdata=%h exp 0/0", rdy(2), rd(2));
      end
      idle(2, 2);
      xfer(2, 1'b0, 32'h8, 32'h0, 0, r, e, c);
      idle(2, 1);
      checks++;
      if (r !== 32'h1111_2222 || e !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_mem data=%h err=%b exp 11112222/0", r, e);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         psel_a[k]    = 1'b0;
         penable_a[k] = 1'b0;
         paddr_a[k]   = '0;
         pwrite_a[k]  = 1'b0;
         pwdata_a[k]  = '0;
      end
      test_reset();
      test_wait_one();
      test_zero_wait();
      test_errors();
      test_latched();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
